// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: MEM-stage opcodes, FSM state, access decode and byte-enable/alignment helpers shared with the hazard unit
package mips_mem_pkg;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24,
                         OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} mem_state_t;
  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_t;
  typedef struct packed {
    logic      access;
    logic      load;
    logic      sext;
    mem_size_t size;
  } mem_op_t;
  function automatic mem_op_t op_decode(input logic [5:0] opc);
    mem_op_t d;
    d = '{access: 1'b0, load: 1'b0, sext: 1'b0, size: SZ_NONE};
    case (opc)
      OP_LB:   d = '{access: 1'b1, load: 1'b1, sext: 1'b1, size: SZ_BYTE};
      OP_LH:   d = '{access: 1'b1, load: 1'b1, sext: 1'b1, size: SZ_HALF};
      OP_LW:   d = '{access: 1'b1, load: 1'b1, sext: 1'b0, size: SZ_WORD};
      OP_LBU:  d = '{access: 1'b1, load: 1'b1, sext: 1'b0, size: SZ_BYTE};
      OP_LHU:  d = '{access: 1'b1, load: 1'b1, sext: 1'b0, size: SZ_HALF};
      OP_SB:   d = '{access: 1'b1, load: 1'b0, sext: 1'b0, size: SZ_BYTE};
      OP_SH:   d = '{access: 1'b1, load: 1'b0, sext: 1'b0, size: SZ_HALF};
      OP_SW:   d = '{access: 1'b1, load: 1'b0, sext: 1'b0, size: SZ_WORD};
      default: d = '{access: 1'b0, load: 1'b0, sext: 1'b0, size: SZ_NONE};
    endcase
    return d;
  endfunction
  function automatic logic [3:0] be_gen(input mem_size_t sz, input logic [1:0] a);
    return sz == SZ_BYTE ? 4'b0001 << a :
           sz == SZ_HALF ? (a[1] ? 4'b1100 : 4'b0011) :
           sz == SZ_WORD ? 4'b1111 : 4'b0000;
  endfunction
  function automatic logic misaligned(input mem_size_t sz, input logic [1:0] a);
    return (sz == SZ_HALF && a[0]) || (sz == SZ_WORD && a != 2'b00);
  endfunction
  function automatic logic [31:0] wdata_gen(input mem_size_t sz, input logic [31:0] rt);
    return sz == SZ_BYTE ? {4{rt[7:0]}} : sz == SZ_HALF ? {2{rt[15:0]}} : rt;
  endfunction
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: selects the addressed byte/half lane of a read word and sign- or zero-extends it
//   word  in  32  raw bus read word
//   lane  in  2   byte address bits [1:0] of the load
//   size  in      access size (byte/half/word)
//   sext  in  1   1 = sign-extend, 0 = zero-extend
//   data  out 32  extended load result
module mem_load_align import mips_mem_pkg::*; (
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  mem_size_t   size,
  input  logic        sext,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = lane == 2'd0 ? word[7:0] : lane == 2'd1 ? word[15:8] : lane == 2'd2 ? word[23:16] : word[31:24];
    h = lane[1] ? word[31:16] : word[15:0];
    data = size == SZ_BYTE ? {{24{sext & b[7]}}, b} :
           size == SZ_HALF ? {{16{sext & h[15]}}, h} :
           size == SZ_WORD ? word : 32'h0;
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage driving the data-memory REQ/ACK bus, stalling the pipeline while an access is outstanding
module mem_access_stage import mips_mem_pkg::*; #(parameter int TIMEOUT_CYCLES = 64) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [5:0]  MEM_Opcode,
  input  logic [31:0] MEM_ALU_RESULT,
  input  logic [31:0] MEM_RT_DATA,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [3:0]  DMEM_BE,
  output logic [31:0] DMEM_WDATA,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_ACK,
  output logic [31:0] MEM_LOAD_DATA,
  output logic        MEM_STALL,
  output logic        MEM_ADDR_ERR,
  output logic        MEM_BUS_ERR
);
  mem_state_t  state;
  mem_op_t     op;
  mem_size_t   size_q;
  logic        ld_q, sext_q, misal, go, tmo;
  logic [1:0]  lane_q;
  logic [31:0] load_q, align_data;
  assign op = op_decode(MEM_Opcode);
  assign misal = misaligned(op.size, MEM_ALU_RESULT[1:0]);
  assign go = state == ST_IDLE && op.access && !misal;
  assign MEM_STALL = RESET_N && (go || state == ST_ACCESS);
  assign MEM_ADDR_ERR = RESET_N && state == ST_IDLE && op.access && misal;
  assign MEM_LOAD_DATA = MEM_ADDR_ERR ? 32'h0 : load_q;
  mem_load_align u_align (
    .word (DMEM_RDATA),
    .lane (lane_q),
    .size (size_q),
    .sext (sext_q),
    .data (align_data)
  );
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          bus_err;
  assign tmo = state == ST_ACCESS && !DMEM_ACK && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign MEM_BUS_ERR = bus_err;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      cnt <= '0;
      bus_err <= 1'b0;
    end else begin
      cnt <= state == ST_ACCESS ? cnt + 1'b1 : '0;
      bus_err <= tmo;
    end
`else
  assign tmo = 1'b0;
  assign MEM_BUS_ERR = 1'b0;
`endif
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state <= ST_IDLE;
      DMEM_REQ <= 1'b0;
      DMEM_WE <= 1'b0;
      DMEM_BE <= 4'h0;
      DMEM_ADDR <= 32'h0;
      DMEM_WDATA <= 32'h0;
      load_q <= 32'h0;
      lane_q <= 2'b00;
      ld_q <= 1'b0;
      sext_q <= 1'b0;
      size_q <= SZ_NONE;
    end else
      case (state)
        ST_IDLE:
          if (go) begin
            state <= ST_ACCESS;
            DMEM_REQ <= 1'b1;
            DMEM_WE <= !op.load;
            DMEM_BE <= be_gen(op.size, MEM_ALU_RESULT[1:0]);
            DMEM_ADDR <= {MEM_ALU_RESULT[31:2], 2'b00};
            DMEM_WDATA <= wdata_gen(op.size, MEM_RT_DATA);
            lane_q <= MEM_ALU_RESULT[1:0];
            ld_q <= op.load;
            sext_q <= op.sext;
            size_q <= op.size;
          end else if (MEM_ADDR_ERR)
            load_q <= 32'h0;
        ST_ACCESS:
          if (DMEM_ACK || tmo) begin
            state <= ST_DONE;
            DMEM_REQ <= 1'b0;
            DMEM_WE <= 1'b0;
            DMEM_BE <= 4'h0;
            load_q <= ld_q && !tmo ? align_data : 32'h0;
          end
        default: state <= ST_IDLE;
      endcase
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed scoreboard bench for the MEM stage bus handshake, alignment and load extension
module tb_mem_access_stage;
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25,
                         SB = 6'h28, SH = 6'h29, SW = 6'h2B, NOP = 6'h00;
  logic        CLK = 1'b0, RESET_N = 1'b0, DMEM_ACK = 1'b0;
  logic [5:0]  MEM_Opcode = '0;
  logic [31:0] MEM_ALU_RESULT = '0, MEM_RT_DATA = '0, DMEM_RDATA = '0;
  logic        DMEM_REQ, DMEM_WE, MEM_STALL, MEM_ADDR_ERR, MEM_BUS_ERR;
  logic [3:0]  DMEM_BE;
  logic [31:0] DMEM_ADDR, DMEM_WDATA, MEM_LOAD_DATA;
  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr, wd, ld;
    int          reqc;
  } exp_t;
  exp_t sb[$];
  int checks = 0, passes = 0;
  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .MEM_Opcode(MEM_Opcode), .MEM_ALU_RESULT(MEM_ALU_RESULT),
    .MEM_RT_DATA(MEM_RT_DATA), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_BE(DMEM_BE), .DMEM_WDATA(DMEM_WDATA), .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK),
    .MEM_LOAD_DATA(MEM_LOAD_DATA), .MEM_STALL(MEM_STALL), .MEM_ADDR_ERR(MEM_ADDR_ERR),
    .MEM_BUS_ERR(MEM_BUS_ERR)
  );
  always #5 CLK = ~CLK;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic next();
    @(posedge CLK);
    #2;
  endtask
  task automatic access(input logic [5:0] op, input logic [31:0] a, rt, rd, input int waits,
                        input logic we, input logic [3:0] be, input logic [31:0] wd, ld);
    exp_t e;
    int nreq;
    sb.push_back('{we, be, {a[31:2], 2'b00}, wd, ld, waits + 1});
    MEM_Opcode = op; MEM_ALU_RESULT = a; MEM_RT_DATA = rt; DMEM_ACK = 0; DMEM_RDATA = 32'h5A5A5A5A;
    #1;
    chk("idle_stall", MEM_STALL, 1);
    chk("idle_req", DMEM_REQ, 0);
    next();
    nreq = 0;
    for (int t = 0; t < 100; t++) begin
      DMEM_ACK = t == waits;
      DMEM_RDATA = t == waits ? rd : 32'h5A5A5A5A;
      #1;
      if (t == 0) begin
        e = sb.pop_front();
        chk("req_we", DMEM_WE, e.we);
        chk("req_be", DMEM_BE, e.be);
        chk("req_addr", DMEM_ADDR, e.addr);
        if (e.we) chk("req_wdata", DMEM_WDATA, e.wd);
      end
      if (DMEM_REQ !== 1'b1) break;
      nreq++;
      if (MEM_STALL !== 1'b1) chk("access_stall", MEM_STALL, 1);
      next();
    end
    DMEM_ACK = 0;
    chk("req_cycles", nreq, e.reqc);
    chk("done_stall", MEM_STALL, 0);
    chk("done_load", MEM_LOAD_DATA, e.ld);
    next();
  endtask
  task automatic bad(input logic [5:0] op, input logic [31:0] a);
    MEM_Opcode = op; MEM_ALU_RESULT = a;
    #1;
    chk("mis_req", DMEM_REQ, 0);
    chk("mis_stall", MEM_STALL, 0);
    chk("mis_err", MEM_ADDR_ERR, 1);
    chk("mis_load", MEM_LOAD_DATA, 0);
    next();
    MEM_Opcode = NOP;
    #1;
    chk("mis_err_pulse", MEM_ADDR_ERR, 0);
    chk("mis_no_req", DMEM_REQ, 0);
    next();
  endtask
  initial begin
    MEM_Opcode = LW; MEM_ALU_RESULT = 32'h100;
    #3;
    chk("rst_ctl", {DMEM_REQ, DMEM_WE, DMEM_BE, MEM_STALL, MEM_ADDR_ERR, MEM_BUS_ERR}, 0);
    chk("rst_addr", DMEM_ADDR, 0);
    chk("rst_wdata", DMEM_WDATA, 0);
    chk("rst_load", MEM_LOAD_DATA, 0);
    next();
    RESET_N = 1; MEM_Opcode = NOP;
    #1;
    chk("nop_stall", MEM_STALL, 0);
    chk("nop_err", MEM_ADDR_ERR, 0);
    next();
    access(SW, 32'h100, 32'hDEADBEEF, 0, 0, 1, 4'hF, 32'hDEADBEEF, 0);
    access(LB, 32'h103, 32'h11223344, 32'h80FF1234, 0, 0, 4'h8, 0, 32'hFFFFFF80);
    access(LBU, 32'h103, 32'h11223344, 32'h80FF1234, 0, 0, 4'h8, 0, 32'h00000080);
    bad(LH, 32'h101);
    bad(LW, 32'h102);
    bad(SW, 32'h101);
    access(LH, 32'h102, 0, 32'h80FF1234, 1, 0, 4'hC, 0, 32'hFFFF80FF);
    access(LHU, 32'h100, 0, 32'h80FF9234, 2, 0, 4'h3, 0, 32'h00009234);
    access(SB, 32'h101, 32'h0000005A, 0, 0, 1, 4'h2, 32'h5A5A5A5A, 0);
    access(LW, 32'h204, 0, 32'hCAFEF00D, 5, 0, 4'hF, 0, 32'hCAFEF00D);
    access(SH, 32'h102, 32'h0000ABCD, 0, 0, 1, 4'hC, 32'hABCDABCD, 0);
    MEM_Opcode = LW; MEM_ALU_RESULT = 32'h300;
    next();
    #1;
    chk("mid_req", DMEM_REQ, 1);
    RESET_N = 0;
    #1;
    chk("arst_req", DMEM_REQ, 0);
    chk("arst_stall", MEM_STALL, 0);
    next();
    DMEM_ACK = 1; DMEM_RDATA = 32'h77777777;
    next();
    RESET_N = 1; MEM_Opcode = NOP;
    #1;
    chk("late_ack_req", DMEM_REQ, 0);
    chk("late_ack_stall", MEM_STALL, 0);
    next();
    #1;
    chk("late_ack_req2", DMEM_REQ, 0);
    chk("late_ack_load", MEM_LOAD_DATA, 0);
    DMEM_ACK = 0;
    next();
    access(LW, 32'h104, 0, 32'h12345678, 1, 0, 4'hF, 0, 32'h12345678);
`ifdef MEM_TIMEOUT_EN
    begin
      int nreq;
      MEM_Opcode = LW; MEM_ALU_RESULT = 32'h200; DMEM_ACK = 0;
      next();
      nreq = 0;
      for (int t = 0; t < 20; t++) begin
        #1;
        if (DMEM_REQ !== 1'b1) break;
        nreq++;
        next();
      end
      chk("tmo_req_cycles", nreq, 4);
      chk("tmo_bus_err", MEM_BUS_ERR, 1);
      chk("tmo_stall", MEM_STALL, 0);
      chk("tmo_load", MEM_LOAD_DATA, 0);
      MEM_Opcode = NOP;
      next();
      #1;
      chk("tmo_pulse", MEM_BUS_ERR, 0);
    end
`endif
    MEM_Opcode = NOP;
    #1;
    chk("final_bus_err", MEM_BUS_ERR, 0);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
